// File: rtl/ascii_num_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ascii_num_pkg
// Brief    : Shared types and ASCII constants for the ASCII number parser.
// Revision : 1.0
// ============================================================================
package ascii_num_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEG   = 3'd1,
        S_DIGIT = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BADCHAR   = 2'd1,
        ERR_MALFORMED = 2'd2,
        ERR_OVERFLOW  = 2'd3
    } err_t;

    localparam logic [7:0] c_ascii_space = 8'h20;
    localparam logic [7:0] c_ascii_minus = 8'h2D;
    localparam logic [7:0] c_ascii_zero  = 8'h30;
    localparam logic [7:0] c_ascii_nine  = 8'h39;

endpackage
`default_nettype wire

// File: rtl/ascii_char_class.sv
`default_nettype none
// ============================================================================
// Module   : ascii_char_class
// Brief    : Combinational classifier for one ASCII character.
// Revision : 1.0
// ============================================================================
module ascii_char_class
    import ascii_num_pkg::*;
(
    input  logic [7:0] char_data,
    output logic       is_digit,
    output logic       is_space,
    output logic       is_minus,
    output logic [3:0] digit_val
);

    always_comb begin
        is_digit  = (char_data >= c_ascii_zero) && (char_data <= c_ascii_nine);
        is_space  = (char_data == c_ascii_space);
        is_minus  = (char_data == c_ascii_minus);
        // '0'..'9' are 0x30..0x39, so the low nibble is the digit value
        digit_val = is_digit ? char_data[3:0] : 4'd0;
    end

endmodule
`default_nettype wire

// File: rtl/ascii_num_parser.sv
`default_nettype none
// ============================================================================
// Module   : ascii_num_parser
// Brief    : Parses space-separated signed decimal ASCII into a number stream.
// Revision : 1.0
// ============================================================================
module ascii_num_parser
    import ascii_num_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic [7:0]             char_data,
    input  logic                   char_valid,
    input  logic                   char_last,
    output logic                   char_ready,
    output logic [DATA_WIDTH-1:0]  num_data,
    output logic                   num_valid,
    output logic                   num_last,
    input  logic                   num_ready,
    output logic [COUNT_WIDTH-1:0] num_count,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             error_code
);

    // Four guard bits keep mag*10+9 from wrapping before the range check
    localparam int c_mag_w = DATA_WIDTH + 4;
    localparam logic [c_mag_w-1:0] c_pos_max =
        {{(c_mag_w-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [c_mag_w-1:0] c_neg_max = c_pos_max + c_mag_w'(1);

    state_t                 r_state, w_state_nxt;
    err_t                   r_err, w_err_nxt;
    logic [c_mag_w-1:0]     r_mag, w_mag_nxt;
    logic                   r_neg, w_neg_nxt;
    logic                   r_last, w_last_nxt;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_live;

    logic                   w_is_digit, w_is_space, w_is_minus, w_is_bad;
    logic [3:0]             w_digit;
    logic [c_mag_w-1:0]     w_digit_ext, w_mag_acc, w_limit;
    logic [DATA_WIDTH-1:0]  w_mag_trunc, w_num_val;
    logic                   w_accept, w_handshake;

    ascii_char_class u_class (
        .char_data (char_data),
        .is_digit  (w_is_digit),
        .is_space  (w_is_space),
        .is_minus  (w_is_minus),
        .digit_val (w_digit)
    );

    assign w_is_bad    = !(w_is_digit || w_is_space || w_is_minus);
    assign w_accept    = char_valid && char_ready;
    assign w_handshake = (r_state == S_EMIT) && num_ready;
    assign w_digit_ext = {{(c_mag_w-4){1'b0}}, w_digit};
    assign w_mag_acc   = r_mag * c_mag_w'(10) + w_digit_ext;
    assign w_limit     = r_neg ? c_neg_max : c_pos_max;
    assign w_mag_trunc = r_mag[DATA_WIDTH-1:0];
    assign w_num_val   = r_neg ? (-w_mag_trunc) : w_mag_trunc;

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_mag_nxt   = r_mag;
        w_neg_nxt   = r_neg;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_bad) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = ERR_BADCHAR;
                    end else if (w_is_digit) begin
                        w_mag_nxt   = w_digit_ext;
                        w_neg_nxt   = 1'b0;
                        w_last_nxt  = char_last;
                        w_state_nxt = char_last ? S_EMIT : S_DIGIT;
                    end else if (w_is_minus) begin
                        w_neg_nxt = 1'b1;
                        if (char_last) begin
                            w_state_nxt = S_ERR;
                            w_err_nxt   = ERR_MALFORMED;
                        end else begin
                            w_state_nxt = S_NEG;
                        end
                    end else if (char_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_NEG: begin
                if (w_accept) begin
                    if (w_is_bad) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = ERR_BADCHAR;
                    end else if (w_is_digit) begin
                        w_mag_nxt   = w_digit_ext;
                        w_last_nxt  = char_last;
                        w_state_nxt = char_last ? S_EMIT : S_DIGIT;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = ERR_MALFORMED;
                    end
                end
            end
            S_DIGIT: begin
                if (w_accept) begin
                    if (w_is_bad) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = ERR_BADCHAR;
                    end else if (w_is_digit) begin
                        if (w_mag_acc > w_limit) begin
                            w_state_nxt = S_ERR;
                            w_err_nxt   = ERR_OVERFLOW;
                        end else begin
                            w_mag_nxt   = w_mag_acc;
                            w_last_nxt  = char_last;
                            w_state_nxt = char_last ? S_EMIT : S_DIGIT;
                        end
                    end else if (w_is_space) begin
                        w_last_nxt  = char_last;
                        w_state_nxt = S_EMIT;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = ERR_MALFORMED;
                    end
                end
            end
            S_EMIT: begin
                if (num_ready) begin
                    w_state_nxt = r_last ? S_DONE : S_IDLE;
                    w_last_nxt  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_err   <= ERR_NONE;
            r_mag   <= '0;
            r_neg   <= 1'b0;
            r_last  <= 1'b0;
            r_count <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            // clear wins over a pending handshake: the number is dropped uncounted
            if (clear) begin
                r_state <= S_IDLE;
                r_err   <= ERR_NONE;
                r_mag   <= '0;
                r_neg   <= 1'b0;
                r_last  <= 1'b0;
                r_count <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_err   <= w_err_nxt;
                r_mag   <= w_mag_nxt;
                r_neg   <= w_neg_nxt;
                r_last  <= w_last_nxt;
                if (w_handshake) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign char_ready = r_live && ((r_state == S_IDLE) || (r_state == S_NEG) ||
                                   (r_state == S_DIGIT));
    assign num_valid  = (r_state == S_EMIT);
    assign num_last   = num_valid && r_last;
    assign num_data   = num_valid ? w_num_val : '0;
    assign num_count  = r_count;
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);
    assign error_code = r_err;

endmodule
`default_nettype wire

// File: doc/ascii_num_parser.md
ASCII_NUM_PARSER -- requirements
Module: ascii_num_parser

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of the signed two's-complement output number.
REQ-002 Parameter COUNT_WIDTH, 16, width of the emitted-number counter.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous restart to IDLE, clears counters and status.
REQ-006 char_data  input  8  ASCII character from the validation stage.
REQ-007 char_valid  input  1  char_data valid.
REQ-008 char_last  input  1  marks the final character of the payload.
REQ-009 char_ready  output  1  parser accepts char_data this cycle.
REQ-010 num_data  output  DATA_WIDTH  parsed signed number.
REQ-011 num_valid  output  1  num_data valid.
REQ-012 num_last  output  1  num_data is the last number; terminated by char_last.
REQ-013 num_ready  input  1  downstream accepts num_data.
REQ-014 num_count  output  COUNT_WIDTH  numbers handed off since reset/clear.
REQ-015 done  output  1  payload fully parsed without error (level).
REQ-016 error  output  1  parse aborted (level).
REQ-017 error_code  output  2  0 NONE, 1 BADCHAR, 2 MALFORMED, 3 OVERFLOW.

Function
REQ-018 States: IDLE (between tokens), NEG ('-' seen, no digit yet), DIGIT (accumulating), EMIT (presenting number), DONE, ERR.
REQ-019 Character accepted = char_valid && char_ready; char_ready = 1 in IDLE/NEG/DIGIT only, else 0.
REQ-020 Character classes: digit 0x30-0x39, space 0x20, minus 0x2D; all others BADCHAR -> ERR in any accepting state.
REQ-021 IDLE: space skipped; digit loads magnitude = digit, sign = +, -> DIGIT; minus -> NEG, sign = -.
REQ-022 NEG: digit loads magnitude, -> DIGIT; space or minus -> ERR, MALFORMED.
REQ-023 DIGIT: digit sets magnitude = magnitude*10 + digit; space -> EMIT; minus -> ERR, MALFORMED.
REQ-024 Overflow: magnitude > 2^(DATA_WIDTH-1)-1 (positive) or > 2^(DATA_WIDTH-1) (negative) after update -> ERR, OVERFLOW; check uses a magnitude register at least DATA_WIDTH+4 bits wide so no intermediate wrap.
REQ-025 char_last accepted in DIGIT (digit or space): -> EMIT with num_last = 1; in IDLE on space: -> DONE; in NEG: -> ERR, MALFORMED; class errors take priority over last.
REQ-026 EMIT: num_valid = 1, num_data = sign-applied magnitude, both stable until num_ready; num_valid asserted the cycle after the terminating character is accepted.
REQ-027 EMIT handshake (num_valid && num_ready): num_count increments (wraps at 2^COUNT_WIDTH), -> DONE if num_last else IDLE.
REQ-028 Trailing spaces after final number: that number emitted with num_last = 0; done asserts on the char_last space; empty/all-space payload gives done with num_count = 0.
REQ-029 DONE and ERR are sticky; char_ready = 0, num_valid = 0; exit only via clear or reset.
REQ-030 clear has priority over all events including a pending EMIT handshake; the pending number is discarded and num_count is not incremented.
REQ-031 error_code holds the first error only; done and error never both 1.

Reset
REQ-032 Under rst_n low: state IDLE; char_ready reads 1 only after release; num_data 0, num_valid 0, num_last 0, num_count 0, done 0, error 0, error_code 0.
REQ-033 Reset mid-number or mid-EMIT discards the partial/pending number with no handshake.

Structure
REQ-034 Package ascii_num_pkg holds the state enum, error_code enum, and ASCII constants (0x20, 0x2D, 0x30, 0x39).
REQ-035 One sub-module, ascii_char_class: combinational classifier giving is_digit, is_space, is_minus, and digit value [3:0].

Verification
REQ-036 "12 -7 0" with last on '0', num_ready = 1 -> 12, -7, 0 out; num_last on 0 only; done = 1; num_count = 3.
REQ-037 DATA_WIDTH=16: "-32768" -> -32768 (0x8000); "32768" -> error = 1, error_code = 3, no num_valid.
REQ-038 "5 -  3": space after '-' -> error_code = 2 after 5 emitted; "4a" -> error_code = 1.
REQ-039 "42 9" with num_ready low 5 cycles in EMIT -> num_data = 42 held stable; char_ready = 0 throughout; proceeds after ready.
REQ-040 "   " with last -> done = 1, num_count = 0; "8  " with last -> 8 emitted with num_last = 0, then done.
REQ-041 clear asserted during EMIT of 77 -> IDLE next cycle, num_count unchanged, num_valid = 0; async reset mid "123" -> all outputs 0.
